// File: rtl/pixel_clk_divider.sv
// Integer clock divider: registered 50%-duty divided clock plus a one-cycle enable strobe.
// Optional runtime ratio input enabled by defining CLKDIV_RUNTIME_DIV_EN.
module pixel_clk_divider #(
    parameter int unsigned DIV_RATIO = 4,
    parameter int unsigned MAX_DIV   = 16,
    localparam int unsigned CNT_W    = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLKDIV_RUNTIME_DIV_EN
    input  logic [CNT_W-1:0] div_ratio,
`endif
    output logic             clk_out,
    output logic             clk_en
);

    // Ratio needs one more bit than the counter so MAX_DIV itself is representable.
    localparam int unsigned RW = CNT_W + 1;

    generate
        if (DIV_RATIO < 2 || DIV_RATIO > MAX_DIV) begin : g_bad_ratio
            $error("pixel_clk_divider: DIV_RATIO %0d outside 2..%0d", DIV_RATIO, MAX_DIV);
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_d, clk_en_d;
    logic [RW-1:0]    ratio_cur, ratio_nxt, half_nxt;
    logic             wrap;

`ifdef CLKDIV_RUNTIME_DIV_EN
    localparam int unsigned REP_MAX   = (1 << CNT_W) - 1;
    localparam int unsigned CLAMP_MAX = (MAX_DIV <= REP_MAX) ? MAX_DIV : REP_MAX;

    logic [RW-1:0] ratio_q, ratio_sel;

    // Clamp the requested ratio into the supported range.
    always_comb begin
        ratio_sel = RW'(div_ratio);
        if (ratio_sel < RW'(2)) begin
            ratio_sel = RW'(2);
        end else if (ratio_sel > RW'(CLAMP_MAX)) begin
            ratio_sel = RW'(CLAMP_MAX);
        end
    end

    // New ratio only takes effect at a period boundary.
    assign ratio_cur = ratio_q;
    assign ratio_nxt = wrap ? ratio_sel : ratio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ratio_q <= RW'(DIV_RATIO);
        end else begin
            ratio_q <= ratio_nxt;
        end
    end
`else
    assign ratio_cur = RW'(DIV_RATIO);
    assign ratio_nxt = RW'(DIV_RATIO);
`endif

    // Outputs are decoded from the next count so they are pure flop outputs.
    always_comb begin
        wrap      = (RW'(cnt_q) == (ratio_cur - RW'(1)));
        cnt_d     = wrap ? '0 : (cnt_q + CNT_W'(1));
        half_nxt  = ratio_nxt >> 1;
        clk_out_d = (RW'(cnt_d) >= half_nxt);
        clk_en_d  = (RW'(cnt_d) == half_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_out <= clk_out_d;
            clk_en  <= clk_en_d;
        end
    end

endmodule

// File: tb/tb_pixel_clk_divider.sv
// Randomised self-checking bench for pixel_clk_divider across several ratios,
// comparing against a period-position model plus a few literal waveform pins.
module tb_pixel_clk_divider;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] out_w;
    logic [NI-1:0] en_w;
`ifdef CLKDIV_RUNTIME_DIV_EN
    logic [3:0] div_ratio = 4'd4;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pixel_clk_divider #(.DIV_RATIO(4), .MAX_DIV(16)) u_r4 (
        .clk(clk), .rst(rst),
`ifdef CLKDIV_RUNTIME_DIV_EN
        .div_ratio(div_ratio),
`endif
        .clk_out(out_w[0]), .clk_en(en_w[0]));
    pixel_clk_divider #(.DIV_RATIO(5), .MAX_DIV(16)) u_r5 (
        .clk(clk), .rst(rst),
`ifdef CLKDIV_RUNTIME_DIV_EN
        .div_ratio(div_ratio),
`endif
        .clk_out(out_w[1]), .clk_en(en_w[1]));
    pixel_clk_divider #(.DIV_RATIO(2), .MAX_DIV(16)) u_r2 (
        .clk(clk), .rst(rst),
`ifdef CLKDIV_RUNTIME_DIV_EN
        .div_ratio(div_ratio),
`endif
        .clk_out(out_w[2]), .clk_en(en_w[2]));
    pixel_clk_divider #(.DIV_RATIO(16), .MAX_DIV(16)) u_r16 (
        .clk(clk), .rst(rst),
`ifdef CLKDIV_RUNTIME_DIV_EN
        .div_ratio(div_ratio),
`endif
        .clk_out(out_w[3]), .clk_en(en_w[3]));
    pixel_clk_divider #(.DIV_RATIO(7), .MAX_DIV(10)) u_r7 (
        .clk(clk), .rst(rst),
`ifdef CLKDIV_RUNTIME_DIV_EN
        .div_ratio(div_ratio),
`endif
        .clk_out(out_w[4]), .clk_en(en_w[4]));

    function automatic int div_of(input int i);
        case (i)
            0: return 4;
            1: return 5;
            2: return 2;
            3: return 16;
            default: return 7;
        endcase
    endfunction

    function automatic int maxd_of(input int i);
        return (i == 4) ? 10 : 16;
    endfunction

    function automatic int clamp_ratio(input int v, input int maxd);
        int rep;
        int mx;
        rep = (1 << $clog2(maxd)) - 1;
        mx  = (maxd <= rep) ? maxd : rep;
        if (v < 2) return 2;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Model: cycles since reset, start cycle and length of each instance's current period.
    int  mdl_n;
    int  mdl_n0 [NI];
    int  mdl_len[NI];
    bit  mdl_valid = 1'b0;
    logic s_rst;
`ifdef CLKDIV_RUNTIME_DIV_EN
    int  s_div;
`endif

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst;
`ifdef CLKDIV_RUNTIME_DIV_EN
            s_div = int'(div_ratio);
`endif
            @(negedge clk);
            if (s_rst) begin
                mdl_valid = 1'b1;
                mdl_n     = 0;
                for (int i = 0; i < NI; i++) begin
                    mdl_n0[i]  = 0;
                    mdl_len[i] = div_of(i);
                end
            end else if (mdl_valid) begin
                mdl_n++;
                for (int i = 0; i < NI; i++) begin
                    if (mdl_n - mdl_n0[i] == mdl_len[i]) begin
                        mdl_n0[i] = mdl_n;
`ifdef CLKDIV_RUNTIME_DIV_EN
                        mdl_len[i] = clamp_ratio(s_div, maxd_of(i));
`endif
                    end
                end
            end
            if (mdl_valid) begin
                for (int i = 0; i < NI; i++) begin
                    int p;
                    int h;
                    p = mdl_n - mdl_n0[i];
                    h = mdl_len[i] / 2;
                    chk($sformatf("model_clk_out[%0d]", i), 32'(out_w[i]), 32'(p >= h));
                    chk($sformatf("model_clk_en[%0d]", i), 32'(en_w[i]), 32'(p == h));
                end
            end
        end
    end

    // Literal waveform pins.
    initial begin
        logic [7:0] exp_o4;
        logic [7:0] exp_e4;
        logic [4:0] exp_o5;
        logic [4:0] exp_e5;
        exp_o4 = 8'h66;
        exp_e4 = 8'h22;
        exp_o5 = 5'b01110;
        exp_e5 = 5'b00010;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_clk_out", 32'(out_w[0]), 32'd0);
        chk("reset_clk_en", 32'(en_w[0]), 32'd0);

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("r4_clk_out_edge%0d", k + 1), 32'(out_w[0]), 32'(exp_o4[k]));
            chk($sformatf("r4_clk_en_edge%0d", k + 1), 32'(en_w[0]), 32'(exp_e4[k]));
            if (k < 5) begin
                chk($sformatf("r5_clk_out_edge%0d", k + 1), 32'(out_w[1]), 32'(exp_o5[k]));
                chk($sformatf("r5_clk_en_edge%0d", k + 1), 32'(en_w[1]), 32'(exp_e5[k]));
            end
            chk($sformatf("r2_clk_out_edge%0d", k + 1), 32'(out_w[2]), 32'(k % 2 == 0));
        end

        // Reset one cycle at count 3 of the ratio-4 instance.
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midreset_clk_out", 32'(out_w[0]), 32'd0);
        chk("midreset_clk_en", 32'(en_w[0]), 32'd0);
        @(negedge clk);
        chk("midreset_edge1_out", 32'(out_w[0]), 32'd0);
        @(negedge clk);
        chk("midreset_edge2_out", 32'(out_w[0]), 32'd1);
        chk("midreset_edge2_en", 32'(en_w[0]), 32'd1);

`ifdef CLKDIV_RUNTIME_DIV_EN
        begin
            logic [9:0] exp_o46;
            exp_o46 = 10'b0111000110;
            @(posedge clk);
            #2 rst = 1'b1;
            div_ratio = 4'd6;
            @(posedge clk);
            #2 rst = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk($sformatf("r4to6_clk_out_edge%0d", k + 1), 32'(out_w[0]), 32'(exp_o46[k]));
            end
        end
`endif

        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            #2;
            rst = ($urandom_range(0, 99) == 0);
`ifdef CLKDIV_RUNTIME_DIV_EN
            if ($urandom_range(0, 7) == 0) begin
                div_ratio = 4'($urandom_range(0, 15));
            end
`endif
        end
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
